bus_datapath_gen: RTL and testbench

- Parametrised single-bus CPU datapath core: general register file, PC, IR, Y, Z (hi/lo), HI, LO, MAR, MDR and a sign-extended constant register, all on one shared bus.
- Register file size and word width are generics.
- Adds a multi-cycle signed MUL/DIV sequencer with a Start/Busy/Done handshake and bus-contention detection.
- Memory stays external and is driven through MAR/MDR ports.
- Sits between the control-unit FSM and the memory block.

---
 rtl/bus_datapath_gen.sv | 260 ++++++++++++++++++++++++++
 tb/tb_bus_datapath_gen.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_datapath_gen.sv
// Single-bus CPU datapath: register file, PC/IR/Y/Z/HI/LO/MAR/MDR/C on one shared bus,
// single-cycle ALU and a multi-cycle signed MUL/DIV sequencer. Optional CON flip-flop: CON_FF_EN.
module bus_datapath_gen #(
  parameter int WIDTH  = 32,
  parameter int NREGS  = 16,
  parameter int MEM_AW = 9
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic [WIDTH-1:0]  Mdatain,
  input  logic              Read,
  input  logic              Gra,
  input  logic              Grb,
  input  logic              Grc,
  input  logic              Rin,
  input  logic              Rout,
  input  logic              BAout,
  input  logic              PCout,
  input  logic              Zhiout,
  input  logic              Zlowout,
  input  logic              MDRout,
  input  logic              HIout,
  input  logic              LOout,
  input  logic              Cout,
  input  logic              MARin,
  input  logic              Zin,
  input  logic              PCin,
  input  logic              MDRin,
  input  logic              IRin,
  input  logic              Yin,
  input  logic              HIin,
  input  logic              LOin,
  input  logic              IncPC,
  input  logic              CONin,
  input  logic [3:0]        AluOp,
  input  logic              Start,
  output logic              Busy,
  output logic              Done,
  output logic [WIDTH-1:0]  BusOut,
  output logic              BusErr,
  output logic [MEM_AW-1:0] MAR,
  output logic [WIDTH-1:0]  MDRo,
  output logic              BranchMet,
  output logic [WIDTH-1:0]  IRo
);
  localparam int RW   = $clog2(NREGS);
  localparam int SW   = $clog2(WIDTH);
  localparam int CW   = WIDTH - 5 - 3*RW;
  localparam int CNTW = $clog2(WIDTH);

  logic [WIDTH-1:0] rf [NREGS];
  logic [WIDTH-1:0] pc, ir, y, zhi, zlo, hi, lo, mar_r, mdr, c_reg;
  logic [WIDTH-1:0] bus, bus_or, rf_out, c_ext;
  logic [RW-1:0]    ra, rb, rc, sel;
  logic [7:0]       src;

  // IR fields, MSB-first below the 5-bit opcode
  assign ra = ir[WIDTH-6 -: RW];
  assign rb = ir[WIDTH-6-RW -: RW];
  assign rc = ir[WIDTH-6-2*RW -: RW];

  generate
    if (CW > 0) begin : g_const
      assign c_ext = {{(WIDTH-CW){ir[CW-1]}}, ir[CW-1:0]};
    end else begin : g_noconst
      assign c_ext = '0;
    end
  endgenerate

  assign sel    = ({RW{Gra}} & ra) | ({RW{Grb}} & rb) | ({RW{Grc}} & rc);
  assign rf_out = (BAout && sel == '0) ? '0 : rf[sel];

  // Bus: OR of enabled sources, forced to 0 on contention
  assign src    = {Rout | BAout, PCout, Zhiout, Zlowout, MDRout, HIout, LOout, Cout};
  assign BusErr = $countones(src) > 1;

  always_comb begin
    bus_or = '0;
    if (src[7]) bus_or = bus_or | rf_out;
    if (src[6]) bus_or = bus_or | pc;
    if (src[5]) bus_or = bus_or | zhi;
    if (src[4]) bus_or = bus_or | zlo;
    if (src[3]) bus_or = bus_or | mdr;
    if (src[2]) bus_or = bus_or | hi;
    if (src[1]) bus_or = bus_or | lo;
    if (src[0]) bus_or = bus_or | c_reg;
    bus = BusErr ? '0 : bus_or;
  end

  assign BusOut = bus;
  assign MAR    = mar_r[MEM_AW-1:0];
  assign MDRo   = mdr;
  assign IRo    = ir;

  always_ff @(posedge Clock) begin
    if (Clear) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      pc <= '0; ir <= '0; y <= '0; hi <= '0; lo <= '0;
      mar_r <= '0; mdr <= '0; c_reg <= '0;
    end else begin
      if (Rin)   rf[sel] <= bus;
      if (PCin)  pc <= bus;
      else if (IncPC) pc <= pc + WIDTH'(1);
      if (IRin)  ir <= bus;
      if (Yin)   y <= bus;
      if (HIin)  hi <= bus;
      if (LOin)  lo <= bus;
      if (MARin) mar_r <= bus;
      if (MDRin) mdr <= Read ? Mdatain : bus;
      c_reg <= c_ext;
    end
  end

  // Single-cycle ALU: A = Y, B = bus
  logic [WIDTH-1:0]   alu_lo, alu_hi;
  logic [31:0]        amt;
  logic [2*WIDTH-1:0] rsh, lsh;

  always_comb begin
    amt    = {{(32-SW){1'b0}}, bus[SW-1:0]} % 32'(WIDTH);
    rsh    = {y, y} >> amt;
    lsh    = {y, y} << amt;
    alu_lo = '0;
    alu_hi = '0;
    case (AluOp)
      4'h0: begin alu_lo = y + bus; alu_hi = {WIDTH{alu_lo[WIDTH-1]}}; end
      4'h1: begin alu_lo = y - bus; alu_hi = {WIDTH{alu_lo[WIDTH-1]}}; end
      4'h2: alu_lo = y & bus;
      4'h3: alu_lo = y | bus;
      4'h4: alu_lo = y >> amt;
      4'h5: alu_lo = y << amt;
      4'h6: alu_lo = rsh[WIDTH-1:0];
      4'h7: alu_lo = lsh[2*WIDTH-1:WIDTH];
      4'h8: alu_lo = -bus;
      4'h9: alu_lo = ~bus;
      default: ;
    endcase
  end

  // MUL/DIV sequencer
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} seq_t;
  seq_t state, nxt;

  logic [CNTW-1:0]    cnt;
  logic               is_div, sa, sb, div0, go, last;
  logic [WIDTH-1:0]   dvd, mp, mag_a, mag_b;
  logic [2*WIDTH-1:0] acc, mc, acc_n, prod;
  logic [WIDTH:0]     rem_sh, trial;
  logic [WIDTH-1:0]   q, r, seq_hi, seq_lo;

  assign go    = (state == S_IDLE) && Start && (AluOp == 4'hA || AluOp == 4'hB);
  assign last  = (state == S_RUN) && (cnt == CNTW'(WIDTH-1));
  assign mag_a = y[WIDTH-1] ? -y : y;
  assign mag_b = bus[WIDTH-1] ? -bus : bus;

  always_ff @(posedge Clock) begin
    if (Clear) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (go) nxt = S_RUN;
      S_RUN:  if (last) nxt = S_DONE;
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    Busy = (state == S_RUN);
    Done = (state == S_DONE);
  end

  // One iteration per cycle on unsigned magnitudes; signs are applied at the end
  always_comb begin
    rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    trial  = rem_sh - {1'b0, mp};
    if (is_div)
      acc_n = trial[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                           : {trial[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
    else
      acc_n = mp[0] ? acc + mc : acc;
    prod = (sa ^ sb) ? -acc_n : acc_n;
    q    = acc_n[WIDTH-1:0];
    r    = acc_n[2*WIDTH-1:WIDTH];
    if (!is_div) begin
      seq_hi = prod[2*WIDTH-1:WIDTH];
      seq_lo = prod[WIDTH-1:0];
    end else if (div0) begin
      seq_hi = dvd;
      seq_lo = '1;
    end else begin
      seq_hi = sa ? -r : r;
      seq_lo = (sa ^ sb) ? -q : q;
    end
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      cnt <= '0; is_div <= 1'b0; sa <= 1'b0; sb <= 1'b0; div0 <= 1'b0;
      dvd <= '0; mp <= '0; acc <= '0; mc <= '0;
    end else if (go) begin
      cnt    <= '0;
      is_div <= AluOp[0];
      sa     <= y[WIDTH-1];
      sb     <= bus[WIDTH-1];
      div0   <= (bus == '0);
      dvd    <= y;
      mp     <= mag_b;
      mc     <= {{WIDTH{1'b0}}, mag_a};
      acc    <= AluOp[0] ? {{WIDTH{1'b0}}, mag_a} : '0;
    end else if (state == S_RUN) begin
      cnt <= cnt + CNTW'(1);
      acc <= acc_n;
      if (!is_div) begin
        mc <= mc << 1;
        mp <= mp >> 1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      zhi <= '0;
      zlo <= '0;
    end else if (last) begin
      zhi <= seq_hi;
      zlo <= seq_lo;
    end else if (Zin && !Busy) begin
      zhi <= alu_hi;
      zlo <= alu_lo;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{ir[WIDTH-1 -: 5], mar_r};

`ifdef CON_FF_EN
  logic con;
  always_ff @(posedge Clock) begin
    if (Clear) con <= 1'b0;
    else if (CONin) begin
      case (rb[1:0])
        2'b00: con <= (bus == '0);
        2'b01: con <= (bus != '0);
        2'b10: con <= !bus[WIDTH-1];
        default: con <= bus[WIDTH-1];
      endcase
    end
  end
  assign BranchMet = con;
`else
  logic unused_con;
  assign unused_con = CONin;
  assign BranchMet  = 1'b0;
`endif

endmodule

// File: tb/tb_bus_datapath_gen.sv
// Directed bench for bus_datapath_gen: scoreboard queue of expected values, immediate assertions.
module tb_bus_datapath_gen;
  localparam int W = 32;

  logic          Clock, Clear, Read;
  logic [W-1:0]  Mdatain;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic PCout, Zhiout, Zlowout, MDRout, HIout, LOout, Cout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, IncPC, CONin;
  logic [3:0]    AluOp;
  logic          Start, Busy, Done, BusErr, BranchMet;
  logic [W-1:0]  BusOut, MDRo, IRo;
  logic [8:0]    MAR;

  bus_datapath_gen #(.WIDTH(W), .NREGS(16), .MEM_AW(9)) dut (
    .Clock(Clock), .Clear(Clear), .Mdatain(Mdatain), .Read(Read),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .Cout(Cout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .CONin(CONin),
    .AluOp(AluOp), .Start(Start), .Busy(Busy), .Done(Done), .BusOut(BusOut),
    .BusErr(BusErr), .MAR(MAR), .MDRo(MDRo), .BranchMet(BranchMet), .IRo(IRo)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic [63:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic tick;
    @(posedge Clock); #1;
  endtask

  task automatic expect_v(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, obs, e);
    end
  endtask

  task automatic idle;
    {Gra, Grb, Grc, Rin, Rout, BAout} = '0;
    {PCout, Zhiout, Zlowout, MDRout, HIout, LOout, Cout} = '0;
    {MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, IncPC, CONin} = '0;
    Read = 1'b0; Start = 1'b0; AluOp = 4'h0;
  endtask

  task automatic put_mdr(input logic [W-1:0] v);
    Mdatain = v; Read = 1'b1; MDRin = 1'b1;
    tick;
    MDRin = 1'b0; Read = 1'b0;
  endtask

  task automatic set_ir(input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc);
    put_mdr({5'd0, ra, rb, rc, 15'd0});
    MDRout = 1'b1; IRin = 1'b1;
    tick;
    MDRout = 1'b0; IRin = 1'b0;
  endtask

  // 0 Zlo, 1 Zhi, 2 PC, 3 Rout/Grb, 4 BAout/Gra, 5 Rout/Gra, 6 MDR, 7 HI
  task automatic rd(input int which, output logic [63:0] v);
    case (which)
      0: Zlowout = 1'b1;
      1: Zhiout  = 1'b1;
      2: PCout   = 1'b1;
      3: begin Rout = 1'b1; Grb = 1'b1; end
      4: begin BAout = 1'b1; Gra = 1'b1; end
      5: begin Rout = 1'b1; Gra = 1'b1; end
      6: MDRout  = 1'b1;
      default: HIout = 1'b1;
    endcase
    #1;
    v = {32'd0, BusOut};
    {Zlowout, Zhiout, PCout, Rout, Grb, BAout, Gra, MDRout, HIout} = '0;
  endtask

  task automatic rd_z(output logic [63:0] v);
    logic [63:0] lo_v, hi_v;
    rd(0, lo_v);
    rd(1, hi_v);
    v = {hi_v[31:0], lo_v[31:0]};
  endtask

  task automatic alu(input logic [3:0] op, input logic [W-1:0] b);
    put_mdr(b);
    MDRout = 1'b1; AluOp = op; Zin = 1'b1;
    tick;
    MDRout = 1'b0; AluOp = 4'h0; Zin = 1'b0;
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    put_mdr(a);
    MDRout = 1'b1; Yin = 1'b1;
    tick;
    Yin = 1'b0; MDRout = 1'b0;
    put_mdr(b);
    MDRout = 1'b1; AluOp = op; Start = 1'b1;
    tick;
    MDRout = 1'b0; AluOp = 4'h0; Start = 1'b0;
  endtask

  typedef struct { logic [3:0] op; logic [W-1:0] b; logic [63:0] z; } alu_vec_t;
  alu_vec_t tbl[12];

  initial begin
    logic [63:0] v;
    int busy_cnt, done_cnt;
    idle();
    Mdatain = '0;
    Clear = 1'b1;
    tick; tick;
    Clear = 1'b0;

    expect_v({25'd0, MAR, W'(0)});
    chk("reset_mar_ir", {25'd0, MAR, IRo});
    expect_v(64'd0);
    chk("reset_flags", {59'd0, Busy, Done, BusErr, BranchMet, |BusOut});
    rd_z(v); expect_v(64'd0); chk("reset_z", v);

    put_mdr(32'h0000_1234);
    expect_v(64'h1234); chk("mdr_read", {32'd0, MDRo});
    MDRout = 1'b1; MARin = 1'b1; tick; idle();
    expect_v(64'h034); chk("mar_low_bits", {55'd0, MAR});

    // R3 = 7, then R3 -> Y, R4 = 5, ADD
    set_ir(4'd0, 4'd3, 4'd0);
    put_mdr(32'd7);
    MDRout = 1'b1; Grb = 1'b1; Rin = 1'b1; tick; idle();
    rd(3, v); expect_v(64'd7); chk("r3_load", v);
    Rout = 1'b1; Grb = 1'b1; Yin = 1'b1; tick; idle();
    set_ir(4'd0, 4'd4, 4'd0);
    put_mdr(32'd5);
    MDRout = 1'b1; Grb = 1'b1; Rin = 1'b1; tick; idle();
    Rout = 1'b1; Grb = 1'b1; Zin = 1'b1; AluOp = 4'h0; tick; idle();
    rd_z(v); expect_v(64'd12); chk("add_r3_r4", v);

    // ALU table with Y = 8000_0001
    tbl[0]  = '{4'h4, 32'd4,          64'h0000_0000_0800_0000};
    tbl[1]  = '{4'h5, 32'd1,          64'h0000_0000_0000_0002};
    tbl[2]  = '{4'h6, 32'd4,          64'h0000_0000_1800_0000};
    tbl[3]  = '{4'h7, 32'd1,          64'h0000_0000_0000_0003};
    tbl[4]  = '{4'h6, 32'd36,         64'h0000_0000_1800_0000};
    tbl[5]  = '{4'h8, 32'd5,          64'h0000_0000_FFFF_FFFB};
    tbl[6]  = '{4'h9, 32'h0F0F_0F0F,  64'h0000_0000_F0F0_F0F0};
    tbl[7]  = '{4'h2, 32'hFFFF_FFFF,  64'h0000_0000_8000_0001};
    tbl[8]  = '{4'h3, 32'd2,          64'h0000_0000_8000_0003};
    tbl[9]  = '{4'h1, 32'd2,          64'h0000_0000_7FFF_FFFF};
    tbl[10] = '{4'h0, 32'd0,          64'hFFFF_FFFF_8000_0001};
    tbl[11] = '{4'hC, 32'd5,          64'h0};
    put_mdr(32'h8000_0001);
    MDRout = 1'b1; Yin = 1'b1; tick; idle();
    for (int i = 0; i < 12; i++) begin
      alu(tbl[i].op, tbl[i].b);
      rd_z(v); expect_v(tbl[i].z); chk($sformatf("alu_%0d", i), v);
    end

    // MUL -6 * 7 with Zin pulsed mid-run
    launch(32'hFFFF_FFFA, 32'd7, 4'hA);
    busy_cnt = 0;
    for (int i = 0; i < W; i++) begin
      if (Busy && !Done) busy_cnt++;
      if (i == 4) Zin = 1'b1;
      if (i == 7) Zin = 1'b0;
      tick;
    end
    expect_v(64'd1); chk("mul_done_pulse", {62'd0, Busy, Done});
    expect_v(64'd32); chk("mul_busy_cycles", 64'(busy_cnt));
    tick;
    expect_v(64'd0); chk("mul_done_clear", {62'd0, Busy, Done});
    rd_z(v); expect_v(64'hFFFF_FFFF_FFFF_FFD6); chk("mul_result", v);

    launch(32'h8000_0000, 32'h8000_0000, 4'hA);
    repeat (W + 1) tick;
    rd_z(v); expect_v(64'h4000_0000_0000_0000); chk("mul_min_min", v);

    launch(32'hFFFF_FFF9, 32'd2, 4'hB);
    repeat (W + 1) tick;
    rd_z(v); expect_v(64'hFFFF_FFFF_FFFF_FFFD); chk("div_neg", v);

    launch(32'd9, 32'd0, 4'hB);
    repeat (W + 1) tick;
    rd_z(v); expect_v(64'h0000_0009_FFFF_FFFF); chk("div_by_zero", v);

    put_mdr(32'd1);
    MDRout = 1'b1; AluOp = 4'h1; Start = 1'b1; tick; idle();
    expect_v(64'd0); chk("start_ignored", {62'd0, Busy, Done});

    // PC wrap, PCin priority
    put_mdr(32'hFFFF_FFFF);
    MDRout = 1'b1; PCin = 1'b1; tick; idle();
    IncPC = 1'b1; tick; idle();
    rd(2, v); expect_v(64'd0); chk("pc_wrap", v);
    put_mdr(32'h55);
    MDRout = 1'b1; PCin = 1'b1; IncPC = 1'b1; tick; idle();
    rd(2, v); expect_v(64'h55); chk("pc_priority", v);

    // Bus contention: Y and HI strobed, load 0; PC and MDR untouched
    put_mdr(32'h77);
    MDRout = 1'b1; HIin = 1'b1; tick; idle();
    PCout = 1'b1; MDRout = 1'b1; Yin = 1'b1; HIin = 1'b1;
    #1;
    expect_v(64'h1_0000_0000); chk("bus_err", {31'd0, BusErr, BusOut});
    tick; idle();
    rd(2, v); expect_v(64'h55); chk("err_pc_kept", v);
    rd(6, v); expect_v(64'h77); chk("err_mdr_kept", v);
    rd(7, v); expect_v(64'h0);  chk("err_hi_zero", v);
    alu(4'h0, 32'd9);
    rd_z(v); expect_v(64'd9); chk("err_y_zero", v);

    // Clear during MUL
    launch(32'd3, 32'd4, 4'hA);
    repeat (9) tick;
    Clear = 1'b1; tick; Clear = 1'b0;
    expect_v(64'd0); chk("abort_busy", {62'd0, Busy, Done});
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (Done) done_cnt++;
      tick;
    end
    expect_v(64'd0); chk("abort_no_done", 64'(done_cnt));
    rd_z(v); expect_v(64'd0); chk("abort_z", v);

    // BAout on R0
    set_ir(4'd0, 4'd0, 4'd0);
    put_mdr(32'd5);
    MDRout = 1'b1; Grb = 1'b1; Rin = 1'b1; tick; idle();
    rd(5, v); expect_v(64'd5); chk("r0_rout", v);
    rd(4, v); expect_v(64'd0); chk("r0_baout", v);

    // CON flip-flop
    set_ir(4'd0, 4'b0011, 4'd0);
    put_mdr(32'hFFFF_FFFF);
    MDRout = 1'b1; CONin = 1'b1; tick; idle();
`ifdef CON_FF_EN
    expect_v(64'd1);
`else
    expect_v(64'd0);
`endif
    chk("con_lt0", {63'd0, BranchMet});
    set_ir(4'd0, 4'b0000, 4'd0);
    put_mdr(32'hFFFF_FFFF);
    MDRout = 1'b1; CONin = 1'b1; tick; idle();
    expect_v(64'd0); chk("con_eq0", {63'd0, BranchMet});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
